// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART byte receiver.
// The serial line is synchronised, then timed by a 16-bit phase accumulator in 1/256-clock units.
// The accumulator keeps the fractional residue, so non-integer clocks-per-bit ratios do not drift.
module uart_byte_rx #(
   parameter real SYSCLOCK = 100.0,  // system clock, MHz
   parameter real BAUDRATE = 12.0    // line rate, Mbit/s
) (
   input  logic       clk,
   input  logic       rst_sync,
   input  logic       uart_rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_frame_err,
   output logic       rx_bsy
);

   // Bit period in 1/256-clock units; int'() of a real rounds to nearest.
   localparam int unsigned BIT_PERIOD  = int'(256.0 * SYSCLOCK / BAUDRATE);
   localparam int unsigned HALF_PERIOD = BIT_PERIOD / 2;

   localparam logic [15:0] BitTarget  = 16'(BIT_PERIOD);
   localparam logic [15:0] HalfTarget = 16'(HALF_PERIOD);
   localparam logic [15:0] AccStep    = 16'd256;

   // Elaboration-time guards on the parameter pair.
   if ((BIT_PERIOD + 256) >= 65536) begin : g_acc_width_check
      $error("uart_byte_rx: BIT_PERIOD+256 does not fit the 16-bit accumulator");
   end
   if ((SYSCLOCK / BAUDRATE) < 4.0) begin : g_ratio_check
      $error("uart_byte_rx: SYSCLOCK/BAUDRATE must be at least 4.0");
   end

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StBreak
   } state_e;

   state_e      state_q;
   logic [1:0]  sync_q;     // [0] first stage, [1] synchronised line
   logic        prev_q;     // synchronised line one cycle earlier, for edge detection
   logic [15:0] acc_q;
   logic [2:0]  bit_idx_q;
   logic [7:0]  shift_q;

   logic        line;
   logic        fall;
   logic [15:0] target;
   logic        sample;
   logic [15:0] acc_next;

   assign line = sync_q[1];
   assign fall = prev_q & ~line;

   // Two-flop synchroniser plus the delayed copy used for falling-edge detection.
   always_ff @(posedge clk) begin
      if (rst_sync) begin
         sync_q <= 2'b11;
         prev_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[0], uart_rx};
         prev_q <= sync_q[1];
      end
   end

   // Sample-event decode: first target after a start edge is half a bit, later ones a full bit.
   always_comb begin
      target   = (state_q == StStart) ? HalfTarget : BitTarget;
      sample   = (acc_q >= target);
      acc_next = sample ? (acc_q + AccStep - target) : (acc_q + AccStep);
   end

   // Receive FSM with registered output pulses and data register.
   always_ff @(posedge clk) begin
      if (rst_sync) begin
         state_q      <= StIdle;
         acc_q        <= 16'd0;
         bit_idx_q    <= 3'd0;
         shift_q      <= 8'h00;
         rx_data      <= 8'h00;
         rx_valid     <= 1'b0;
         rx_frame_err <= 1'b0;
      end else begin
         rx_valid     <= 1'b0;
         rx_frame_err <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (fall) begin
                  state_q   <= StStart;
                  acc_q     <= 16'd0;
                  bit_idx_q <= 3'd0;
               end
            end
            StStart: begin
               acc_q <= acc_next;
               if (sample) begin
                  // A high line at mid start bit was a glitch, not a start bit.
                  state_q <= line ? StIdle : StData;
               end
            end
            StData: begin
               acc_q <= acc_next;
               if (sample) begin
                  shift_q   <= {line, shift_q[7:1]};
                  bit_idx_q <= bit_idx_q + 3'd1;
                  if (bit_idx_q == 3'd7) begin
                     state_q <= StStop;
                  end
               end
            end
            StStop: begin
               acc_q <= acc_next;
               if (sample) begin
                  if (line) begin
                     rx_data  <= shift_q;
                     rx_valid <= 1'b1;
                     state_q  <= StIdle;
                  end else begin
                     rx_frame_err <= 1'b1;
                     state_q      <= StBreak;
                  end
               end
            end
            StBreak: begin
               // Wait out a held-low line so its release cannot look like a start edge.
               if (line) begin
                  state_q <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign rx_bsy = (state_q != StIdle);

   // A byte is either good or badly framed, never both.
   a_pulse_exclusive : assert property (@(posedge clk) !(rx_valid && rx_frame_err));

   // Accumulator never exceeds one bit period plus one step.
   a_acc_bounded : assert property (@(posedge clk) disable iff (rst_sync)
      (acc_q <= BitTarget + AccStep));

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: scoreboard bench for uart_byte_rx (100 MHz clock, 12 Mbit/s default).
// Time unit is the simulator default; one clock period is 100 units.
module tb_uart_byte_rx;

   localparam real NOM_P = 100.0 / 12.0;  // nominal clocks per bit

   logic       clk;
   logic       rst_sync;
   logic       uart_rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_frame_err;
   logic       rx_bsy;

   uart_byte_rx #(
      .SYSCLOCK(100.0),
      .BAUDRATE(12.0)
   ) dut (
      .clk         (clk),
      .rst_sync    (rst_sync),
      .uart_rx     (uart_rx),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_frame_err(rx_frame_err),
      .rx_bsy      (rx_bsy)
   );

   // Posedges at 50 + 100*n.
   initial begin
      clk = 1'b0;
      forever #50 clk = ~clk;
   end

   typedef struct packed {
      logic       is_err;
      logic [7:0] data;
   } exp_t;

   exp_t       exp_q[$];
   int         checks = 0;
   int         errors = 0;
   logic [7:0] last_data = 8'h00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h at time %0t", name, act, req, $time);
      end
   endtask

   task automatic wait_until(input longint t);
      longint now;
      now = longint'($time);
      if (t > now) #(t - now);
   endtask

   // Keep line transitions clear of the rising clock edge.
   function automatic longint edge_safe(input real t);
      longint r;
      longint m;
      r = longint'(t);
      m = r % 100;
      if (m >= 47 && m <= 53) r = r + 7;
      return r;
   endfunction

   // Drive one frame: start bit, ndata data bits LSB first and, if ndata == 8, the stop bit.
   // A complete frame queues its expected outcome: a valid byte if the stop bit is 1,
   // otherwise a framing error.
   task automatic send_frame(input logic [7:0] data, input real per_clk, input bit align,
                             input real phase, input logic stop_val, input int ndata,
                             input bit chk_bsy);
      real        p;
      real        t0;
      int         nbits;
      logic [9:0] bits;
      exp_t       e;
      p     = per_clk * 100.0;
      bits  = {stop_val, data, 1'b0};
      nbits = (ndata == 8) ? 10 : ndata + 1;
      if (align) begin
         @(posedge clk);
         #(longint'(phase * 100.0));
      end
      t0 = $realtime;
      if (ndata == 8) begin
         e.is_err = ~stop_val;
         e.data   = data;
         exp_q.push_back(e);
      end
      for (int k = 0; k < nbits; k++) begin
         wait_until(edge_safe(t0 + k * p));
         uart_rx = bits[k];
         if (chk_bsy) begin
            wait_until(longint'(t0 + (k + 0.5) * p));
            @(negedge clk);
            check("bsy_in_frame", {31'd0, rx_bsy}, 32'd1);
         end
      end
      wait_until(edge_safe(t0 + nbits * p));
   endtask

   task automatic idle_line(input real nbits, input real per_clk);
      uart_rx = 1'b1;
      #(longint'(nbits * per_clk * 100.0));
   endtask

   // Monitor: reset values, pulse exclusivity, scoreboard pops and rx_data stability.
   initial begin : monitor
      logic rst_prev;
      exp_t e;
      rst_prev = 1'b1;
      forever begin
         @(negedge clk);
         if (rst_prev) begin
            check("reset_rx_data", {24'd0, rx_data}, 32'd0);
            check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
            check("reset_rx_frame_err", {31'd0, rx_frame_err}, 32'd0);
            check("reset_rx_bsy", {31'd0, rx_bsy}, 32'd0);
            last_data = 8'h00;
         end else begin
            check("valid_err_exclusive", {31'd0, rx_valid & rx_frame_err}, 32'd0);
            if (rx_valid || rx_frame_err) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_pulse: got valid=%0b err=%0b data=%02h, required no pulse",
                           rx_valid, rx_frame_err, rx_data);
               end else begin
                  e = exp_q.pop_front();
                  check("pulse_is_err", {31'd0, rx_frame_err}, {31'd0, e.is_err});
                  if (rx_valid) begin
                     check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
                     last_data = e.data;
                  end else begin
                     check("rx_data_kept_on_err", {24'd0, rx_data}, {24'd0, last_data});
                  end
               end
            end else begin
               check("rx_data_stable", {24'd0, rx_data}, {24'd0, last_data});
            end
         end
         rst_prev = rst_sync;
      end
   end

   initial begin : stimulus
      real  per;
      int   gap;
      logic stop_val;
      logic last_stop;
      rst_sync = 1'b1;
      uart_rx  = 1'b1;
      repeat (4) @(posedge clk);
      #20 rst_sync = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("idle_bsy", {31'd0, rx_bsy}, 32'd0);

      // Single frame at the nominal rate.
      send_frame(8'hA5, NOM_P, 1'b1, 0.4, 1'b1, 8, 1'b1);
      idle_line(3.0, NOM_P);

      // Back-to-back frames, no idle gap.
      send_frame(8'h00, NOM_P, 1'b1, 0.6, 1'b1, 8, 1'b1);
      send_frame(8'hFF, NOM_P, 1'b0, 0.0, 1'b1, 8, 1'b1);
      send_frame(8'h55, NOM_P, 1'b0, 0.0, 1'b1, 8, 1'b1);
      idle_line(3.0, NOM_P);

      // Glitch: line low for 3 clocks only.
      @(posedge clk);
      #30 uart_rx = 1'b0;
      #300 uart_rx = 1'b1;
      @(negedge clk);
      check("glitch_bsy_set", {31'd0, rx_bsy}, 32'd1);
      repeat (7) @(negedge clk);
      check("glitch_bsy_clear", {31'd0, rx_bsy}, 32'd0);
      idle_line(2.0, NOM_P);

      // Bad stop bit, line held low for 20 bit times, then a good frame.
      send_frame(8'h3C, NOM_P, 1'b1, 0.5, 1'b0, 8, 1'b1);
      for (int i = 0; i < 20; i++) begin
         #(longint'(NOM_P * 100.0));
         @(negedge clk);
         check("break_bsy", {31'd0, rx_bsy}, 32'd1);
      end
      idle_line(2.0, NOM_P);
      @(negedge clk);
      check("break_released_bsy", {31'd0, rx_bsy}, 32'd0);
      send_frame(8'h81, NOM_P, 1'b1, 0.3, 1'b1, 8, 1'b0);
      idle_line(2.0, NOM_P);

      // Reset after data bit 4 of 0x6E, then a fresh frame.
      send_frame(8'h6E, NOM_P, 1'b1, 0.5, 1'b1, 5, 1'b0);
      @(posedge clk);
      #20;
      rst_sync = 1'b1;
      uart_rx  = 1'b1;
      repeat (2) @(posedge clk);
      #20 rst_sync = 1'b0;
      idle_line(2.0, NOM_P);
      send_frame(8'h12, NOM_P, 1'b1, 0.7, 1'b1, 8, 1'b0);
      idle_line(2.0, NOM_P);

      // Rate tolerance: slow and fast ends.
      send_frame(8'h96, 8.17, 1'b1, 0.5, 1'b1, 8, 1'b0);
      idle_line(2.0, NOM_P);
      send_frame(8'h96, 8.50, 1'b1, 0.3, 1'b1, 8, 1'b0);
      idle_line(2.0, NOM_P);

      // Randomised frames: random data, rate, phase, gap and occasional bad stop bit.
      last_stop = 1'b1;
      for (int n = 0; n < 40; n++) begin
         per      = 8.25 + real'($urandom_range(0, 25)) / 100.0;
         gap      = $urandom_range(0, 2);
         stop_val = ($urandom_range(0, 7) != 0);
         if (!last_stop && gap == 0) gap = 1;
         if (gap > 0) begin
            idle_line(real'(gap), per);
            send_frame(8'($urandom), per, 1'b1, real'($urandom_range(10, 90)) / 100.0,
                       stop_val, 8, 1'b0);
         end else begin
            send_frame(8'($urandom), per, 1'b0, 0.0, stop_val, 8, 1'b0);
         end
         last_stop = stop_val;
      end
      idle_line(2.0, NOM_P);

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 32'd0);
      repeat (4) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
